pc_stall_ctrl: RTL and testbench
================================

PC_STALL_CTRL -- requirements
Module: pc_stall_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 4, meaning multiply/divide stall length in cycles, legal range 1..15.
REQ-002 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_id_rs  input  5  rs of instruction in ID.
REQ-005 SHALL have port i_id_rt  input  5  rt of instruction in ID.
REQ-006 SHALL have port i_id_uses_rt  input  1  ID instruction reads rt.
REQ-007 SHALL have port i_ex_memread  input  1  EX instruction is a load.
REQ-008 SHALL have port i_ex_rt  input  5  load destination register in EX.
REQ-009 SHALL have port i_mdu_start  input  1  EX instruction is mult/div.
REQ-010 SHALL have port i_branch_taken  input  1  taken branch or jump resolved this cycle.
REQ-011 SHALL have port o_no_change_pc  output  1  PC hold, driven to PC hold input.
REQ-012 SHALL have port o_ifid_write  output  1  IF/ID register load enable.
REQ-013 SHALL have port o_ifid_flush  output  1  IF/ID register cleared to NOP.
REQ-014 SHALL have port o_idex_bubble  output  1  ID/EX loads NOP instead of ID instruction.
REQ-015 SHALL have port o_ex_hold  output  1  EX/MEM-side hold during MDU operation.
REQ-016 SHALL have port o_mdu_busy  output  1  FSM in MDU_WAIT.

Function
REQ-017 SHALL implement FSM states RUN and MDU_WAIT plus 4-bit down-counter cnt; outputs combinational from state and inputs.
REQ-018 SHALL define load_use = i_ex_memread & (i_ex_rt != 0) & ((i_ex_rt == i_id_rs) | (i_id_uses_rt & (i_ex_rt == i_id_rt))).
REQ-019 SHALL, in RUN with i_branch_taken=1: o_ifid_flush=1, o_no_change_pc=0, o_ifid_write=1, o_idex_bubble=1; load_use ignored (flush priority).
REQ-020 SHALL, in RUN with load_use=1 and i_branch_taken=0: o_no_change_pc=1, o_ifid_write=0, o_idex_bubble=1, o_ifid_flush=0; exactly one stall cycle per hazard.
REQ-021 SHALL, in RUN with no event: o_no_change_pc=0, o_ifid_write=1, o_ifid_flush=0, o_idex_bubble=0, o_ex_hold=0.
REQ-022 SHALL, in RUN with i_mdu_start=1, transition to MDU_WAIT at next edge, loading cnt=MDU_LAT-1; same-cycle branch flush/load-use actions still apply.
REQ-023 SHALL, in MDU_WAIT: o_no_change_pc=1, o_ifid_write=0, o_ex_hold=1, o_mdu_busy=1, o_ifid_flush=0, o_idex_bubble=0.
REQ-024 SHALL decrement cnt each MDU_WAIT cycle; cnt==0 in MDU_WAIT returns to RUN at next edge, giving exactly MDU_LAT stall cycles.
REQ-025 SHALL ignore i_mdu_start, i_branch_taken and load_use while in MDU_WAIT.
REQ-026 SHALL deassert all stall outputs in the first RUN cycle after MDU_WAIT unless a new event is present.

Reset
REQ-027 SHALL, on rising edge with i_reset=1, set state=RUN, cnt=0, stall counter=0, overriding all other inputs, including mid-MDU_WAIT.
REQ-028 SHALL, while i_reset=1, drive o_ifid_flush=1, o_idex_bubble=1, o_ifid_write=1, o_no_change_pc=0, o_ex_hold=0, o_mdu_busy=0.

Configuration
REQ-029 SHALL, with PC_STALL_CNT_EN defined, add port o_stall_cycles output 32 counting cycles with o_no_change_pc=1 and i_reset=0, saturating at 32'hFFFFFFFF.
REQ-030 SHALL, without PC_STALL_CNT_EN, omit o_stall_cycles and its counter; all other behaviour identical.

Verification
REQ-031 SHALL cover load-use: i_ex_memread=1, i_ex_rt=8, i_id_rs=8 one cycle -> o_no_change_pc=1, o_idex_bubble=1 for exactly 1 cycle; with i_ex_rt=0 -> no stall.
REQ-032 SHALL cover branch priority: load_use=1 and i_branch_taken=1 same cycle -> o_ifid_flush=1, o_no_change_pc=0.
REQ-033 SHALL cover MDU: MDU_LAT=4, i_mdu_start pulse -> o_mdu_busy=1 and o_no_change_pc=1 for exactly 4 cycles starting next cycle; MDU_LAT=1 -> 1 cycle.
REQ-034 SHALL cover reset mid-MDU_WAIT: i_reset at 2nd busy cycle -> o_mdu_busy=0 after edge, state RUN, o_ifid_flush=1 during reset.
REQ-035 SHALL cover counter (PC_STALL_CNT_EN): one load-use stall + one MDU_LAT=4 op -> o_stall_cycles=5; preset near max -> holds 32'hFFFFFFFF.

Source files
------------

// File: rtl/pc_stall_ctrl.sv
// rtl/pc_stall_ctrl.sv - pipeline PC/IF-ID stall, flush and MDU hold control
// Optional stall-cycle counter port enabled by defining PC_STALL_CNT_EN.
module pc_stall_ctrl #(
    parameter int MDU_LAT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_uses_rt,
    input  logic        i_ex_memread,
    input  logic [4:0]  i_ex_rt,
    input  logic        i_mdu_start,
    input  logic        i_branch_taken,
    output logic        o_no_change_pc,
    output logic        o_ifid_write,
    output logic        o_ifid_flush,
    output logic        o_idex_bubble,
    output logic        o_ex_hold,
    output logic        o_mdu_busy
`ifdef PC_STALL_CNT_EN
    ,
    output logic [31:0] o_stall_cycles
`endif
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MDU_WAIT = 1'b1;

    // Counter reloads one short so MDU_WAIT lasts exactly MDU_LAT cycles.
    localparam logic [3:0] CNT_LOAD = 4'(MDU_LAT - 1);

    logic [0:0] state;
    logic [3:0] cnt;
    logic       load_use;

    assign load_use = i_ex_memread & (i_ex_rt != 5'd0) &
                      ((i_ex_rt == i_id_rs) | (i_id_uses_rt & (i_ex_rt == i_id_rt)));

    always_comb begin
        o_no_change_pc = 1'b0;
        o_ifid_write   = 1'b1;
        o_ifid_flush   = 1'b0;
        o_idex_bubble  = 1'b0;
        o_ex_hold      = 1'b0;
        o_mdu_busy     = 1'b0;
        if (i_reset) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
        end else if (state == MDU_WAIT) begin
            o_no_change_pc = 1'b1;
            o_ifid_write   = 1'b0;
            o_ex_hold      = 1'b1;
            o_mdu_busy     = 1'b1;
        end else if (i_branch_taken) begin
            // Flush wins over a load-use stall: the stalled instruction is discarded anyway.
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
        end else if (load_use) begin
            o_no_change_pc = 1'b1;
            o_ifid_write   = 1'b0;
            o_idex_bubble  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (i_mdu_start) begin
                        state <= MDU_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                MDU_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef PC_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt <= 32'd0;
        end else if (o_no_change_pc && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign o_stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// tb/tb_pc_stall_ctrl.sv - directed vector and sequence bench for pc_stall_ctrl
module tb_pc_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       uses_rt, memread, mdu_start, br;

    logic nochg0, wr0, fl0, bub0, hold0, busy0;
    logic nochg1, wr1, fl1, bub1, hold1, busy1;
`ifdef PC_STALL_CNT_EN
    logic [31:0] stall0, stall1;
`endif

    logic [5:0] got0, got1;
    assign got0 = {nochg0, wr0, fl0, bub0, hold0, busy0};
    assign got1 = {nochg1, wr1, fl1, bub1, hold1, busy1};

    // Output patterns as {no_change_pc, ifid_write, ifid_flush, idex_bubble, ex_hold, mdu_busy}
    localparam logic [5:0] E_RUN   = 6'b010000;
    localparam logic [5:0] E_STALL = 6'b100100;
    localparam logic [5:0] E_FLUSH = 6'b011100;
    localparam logic [5:0] E_MDU   = 6'b100011;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_stall_ctrl #(.MDU_LAT(4)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(uses_rt), .i_ex_memread(memread), .i_ex_rt(ex_rt),
        .i_mdu_start(mdu_start), .i_branch_taken(br),
        .o_no_change_pc(nochg0), .o_ifid_write(wr0), .o_ifid_flush(fl0),
        .o_idex_bubble(bub0), .o_ex_hold(hold0), .o_mdu_busy(busy0)
`ifdef PC_STALL_CNT_EN
        , .o_stall_cycles(stall0)
`endif
    );

    pc_stall_ctrl #(.MDU_LAT(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(uses_rt), .i_ex_memread(memread), .i_ex_rt(ex_rt),
        .i_mdu_start(mdu_start), .i_branch_taken(br),
        .o_no_change_pc(nochg1), .o_ifid_write(wr1), .o_ifid_flush(fl1),
        .o_idex_bubble(bub1), .o_ex_hold(hold1), .o_mdu_busy(busy1)
`ifdef PC_STALL_CNT_EN
        , .o_stall_cycles(stall1)
`endif
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; caller drives, then waits before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; id_rs = 5'd1; id_rt = 5'd2; uses_rt = 1'b1;
        memread = 1'b0; ex_rt = 5'd0; mdu_start = 1'b0; br = 1'b0;
    endtask

    task automatic load_use_in();
        idle();
        memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    endtask

    task automatic do_reset();
        cyc(); idle(); rst = 1'b1;
        cyc(); idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{5'd8,  5'd9, 1'b1, 1'b0, 5'd8,  1'b0, E_RUN};
        vecs[1] = '{5'd8,  5'd9, 1'b1, 1'b1, 5'd8,  1'b0, E_STALL};
        vecs[2] = '{5'd0,  5'd0, 1'b1, 1'b1, 5'd0,  1'b0, E_RUN};
        vecs[3] = '{5'd3,  5'd8, 1'b1, 1'b1, 5'd8,  1'b0, E_STALL};
        vecs[4] = '{5'd3,  5'd8, 1'b0, 1'b1, 5'd8,  1'b0, E_RUN};
        vecs[5] = '{5'd8,  5'd9, 1'b1, 1'b1, 5'd8,  1'b1, E_FLUSH};
        vecs[6] = '{5'd4,  5'd5, 1'b1, 1'b0, 5'd6,  1'b1, E_FLUSH};
        vecs[7] = '{5'd31, 5'd2, 1'b0, 1'b1, 5'd31, 1'b0, E_STALL};
        vecs[8] = '{5'd4,  5'd5, 1'b1, 1'b1, 5'd6,  1'b0, E_RUN};
        vecs[9] = '{5'd7,  5'd7, 1'b1, 1'b1, 5'd7,  1'b0, E_STALL};

        idle();
        rst = 1'b1; mdu_start = 1'b1; memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        cyc(); #3;
        check("reset_outputs", 32'(got0), 32'(E_FLUSH));
        check("reset_outputs_lat1", 32'(got1), 32'(E_FLUSH));
        cyc(); idle(); #3;
        check("after_reset_run", 32'(got0), 32'(E_RUN));

        for (int i = 0; i < 10; i++) begin
            cyc();
            idle();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; uses_rt = vecs[i].uses_rt;
            memread = vecs[i].memread; ex_rt = vecs[i].ex_rt; br = vecs[i].br;
            #3;
            check($sformatf("vec%0d", i), 32'(got0), 32'(vecs[i].exp));
        end

        // Single load-use pulse stalls for exactly one cycle
        cyc(); load_use_in(); #3;
        check("lu_pulse_stall", 32'(got0), 32'(E_STALL));
        cyc(); idle(); #3;
        check("lu_pulse_release", 32'(got0), 32'(E_RUN));

        // MDU op: LAT=4 busy four cycles, LAT=1 busy one cycle
        cyc(); idle(); mdu_start = 1'b1; #3;
        check("mdu_start_cycle", 32'(got0), 32'(E_RUN));
        for (int k = 0; k < 4; k++) begin
            cyc(); idle(); #3;
            check($sformatf("mdu4_busy%0d", k), 32'(got0), 32'(E_MDU));
            check($sformatf("mdu1_cyc%0d", k), 32'(got1), 32'((k == 0) ? E_MDU : E_RUN));
        end
        cyc(); idle(); #3;
        check("mdu4_done", 32'(got0), 32'(E_RUN));

        // Events during MDU_WAIT are ignored and do not restart the op
        do_reset();
        mdu_start = 1'b1;
        cyc(); idle(); #3;
        check("ign_busy1", 32'(got0), 32'(E_MDU));
        cyc(); load_use_in(); br = 1'b1; mdu_start = 1'b1; #3;
        check("ign_busy2_events", 32'(got0), 32'(E_MDU));
        cyc(); idle(); #3;
        check("ign_busy3", 32'(got0), 32'(E_MDU));
        cyc(); idle(); #3;
        check("ign_busy4", 32'(got0), 32'(E_MDU));
        cyc(); idle(); #3;
        check("ign_done", 32'(got0), 32'(E_RUN));

        // Branch flush applies in the same cycle that launches the MDU
        cyc(); idle(); br = 1'b1; mdu_start = 1'b1; #3;
        check("br_mdu_same_cycle", 32'(got0), 32'(E_FLUSH));
        cyc(); idle(); #3;
        check("br_mdu_next_busy", 32'(got0), 32'(E_MDU));
        do_reset();

        // Reset on the second busy cycle aborts the MDU wait
        mdu_start = 1'b1;
        cyc(); idle(); #3;
        check("rst_mid_busy1", 32'(got0), 32'(E_MDU));
        cyc(); idle(); rst = 1'b1; #3;
        check("rst_mid_flush", 32'(got0), 32'(E_FLUSH));
        cyc(); idle(); #3;
        check("rst_mid_after", 32'(got0), 32'(E_RUN));
        cyc(); idle(); #3;
        check("rst_mid_stays_run", 32'(got0), 32'(E_RUN));

`ifdef PC_STALL_CNT_EN
        do_reset(); #3;
        check("cnt_reset", stall0, 32'd0);
        cyc(); load_use_in();
        cyc(); idle(); mdu_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(); idle();
        end
        cyc(); idle(); #3;
        check("cnt_five", stall0, 32'd5);
        force dut0.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut0.stall_cnt;
        for (int k = 0; k < 3; k++) begin
            cyc(); load_use_in();
        end
        cyc(); idle(); #3;
        check("cnt_saturate", stall0, 32'hFFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
